spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops that synchronize sck/ss/mosi into clk (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have ports ss  input  1  slave select, active-low; sck  input  1  serial clock; mosi  input  1  serial data in.
REQ-005 SHALL have ports miso  output  1  serial data out; miso_oe  output  1  miso tri-state enable (high = drive).
REQ-006 SHALL have ports cpol  input  1  and cpha  input  1  mode select; xfer_len  input  4  frame length minus one (1..16 bits).
REQ-007 SHALL have ports we  input  1  tx load strobe; tx_data  input  16  word to send, right-aligned.
REQ-008 SHALL have ports rx_data  output  16  last received word, right-aligned; rx_valid  output  1  new word pending; rd  input  1  clears rx_valid.
REQ-009 SHALL have ports busy  output  1  frame in progress; tx_empty  output  1  holding register consumed; overrun  output  1  sticky overrun flag.

Function
REQ-010 SHALL synchronize sck, ss, mosi through SYNC_STAGES flops; all edge detection uses synchronized values; sck frequency SHALL be at most clk/8.
REQ-011 SHALL implement states S_IDLE, S_SHIFT, S_WAIT; S_IDLE->S_SHIFT on synchronized ss falling; S_SHIFT->S_WAIT on final sample; S_WAIT->S_IDLE on ss rising.
REQ-012 SHALL latch cpol, cpha, xfer_len at ss falling; changes mid-frame SHALL be ignored.
REQ-013 SHALL copy the tx holding register into the shift register at ss falling and set tx_empty the same cycle.
REQ-014 SHALL shift MSB-first: bit xfer_len of the word first, bit 0 last.
REQ-015 SHALL, leading edge = sck leaving cpol level, trailing edge = sck returning to cpol level.
REQ-016 SHALL, cpha=0: present first bit on miso at ss falling, sample mosi on leading edges, shift out next bit on trailing edges.
REQ-017 SHALL, cpha=1: shift out a bit on each leading edge, sample mosi on trailing edges.
REQ-018 SHALL count samples with a 5-bit counter; frame complete when count equals xfer_len+1.
REQ-019 SHALL load rx_data (upper unused bits zero) and set rx_valid one clk after the cycle the final sample edge is detected.
REQ-020 SHALL hold rx_valid until rd; rd and a frame completion in the same cycle SHALL leave rx_valid set with the new word.
REQ-021 SHALL, with rx_valid already set at frame completion, overwrite rx_data (see REQ-030 for overrun).
REQ-022 SHALL drive miso_oe high only while synchronized ss is low; miso SHALL be 0 when miso_oe is low.
REQ-023 SHALL, on ss rising before frame completion, abort to S_IDLE, discard partial data, leave rx_valid/rx_data unchanged.
REQ-024 SHALL load the holding register on we in any state and clear tx_empty; a frame starting with tx_empty set retransmits the stale holding value.
REQ-025 SHALL assert busy in S_SHIFT and S_WAIT.
REQ-026 SHALL ignore sck edges in S_IDLE and S_WAIT.

Reset
REQ-027 SHALL on rst: state S_IDLE, miso 0, miso_oe 0, busy 0, rx_valid 0, rx_data 0, tx_empty 1, overrun 0, holding and shift registers 0, counter 0, synchronizers to ss=1, sck=0, mosi=0.
REQ-028 SHALL on rst mid-frame return to S_IDLE immediately and require a fresh ss falling edge to start.

Configuration
REQ-029 SHALL use macro SPI_TARGET_OVERRUN_EN.
REQ-030 SHALL with macro defined: set overrun when a frame completes while rx_valid is set and rd not asserted that cycle; clear only on rst.
REQ-031 SHALL without macro: overrun tied 0, no overrun logic; REQ-021 overwrite unchanged.

Structure
REQ-032 SHALL place state encodings (S_IDLE=0, S_SHIFT=1, S_WAIT=2) and max frame width 16 in shared package spi_pkg, reused by flex_spi users.
REQ-033 SHALL use one sub-module spi_sync (parameterized multi-flop synchronizer with reset value), instantiated per input.

Verification
REQ-034 SHALL cover: cpol=0 cpha=0 xfer_len=7, tx 0xA5, master sends 0x3C -> miso 1,0,1,0,0,1,0,1; rx_data=0x003C, rx_valid=1.
REQ-035 SHALL cover: cpol=1 cpha=1 xfer_len=15, tx 0x1234, master sends 0xBEEF -> miso carries 0x1234, rx_data=0xBEEF.
REQ-036 SHALL cover: ss rises after 3 of 8 bits -> state S_IDLE, rx_valid stays 0, rx_data unchanged.
REQ-037 SHALL cover: two 8-bit frames 0x11,0x22 without rd, macro defined -> rx_data=0x0022, overrun=1; macro undefined -> overrun=0.
REQ-038 SHALL cover: rst asserted mid-frame -> all outputs at REQ-027 values same cycle; next frame with tx 0x5A received correctly.
REQ-039 SHALL cover: no we between frames -> tx_empty=1, second frame retransmits previous word.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI target and other flex_spi users.
//   S_IDLE / S_SHIFT / S_WAIT : frame state encodings (2 bits)
//   SPI_MAX_W                 : maximum frame width in bits
//   spi_cfg_t                 : mode/length captured at the start of a frame
package spi_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam int SPI_MAX_W = 16;

    typedef struct packed {
        logic       cpol;
        logic       cpha;
        logic [3:0] len;   // frame length minus one
    } spi_cfg_t;

endpackage

// File: rtl/spi_sync.sv
// spi_sync -- multi-flop synchronizer with a configurable reset value.
//   clk, rst : destination clock, asynchronous active-high reset
//   i_d      : asynchronous input
//   o_q      : synchronized output (STAGES clocks of latency)
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_chain <= {STAGES{RST_VAL}};
        else     r_chain <= {r_chain[STAGES-2:0], i_d};
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// spi_target -- SPI target (slave), modes 0..3, 1..16-bit frames, MSB first.
// Optional feature: define SPI_TARGET_OVERRUN_EN to enable the sticky
// overrun flag; otherwise overrun is tied low.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   ss, sck, mosi       raw SPI inputs (ss active low)
//   miso, miso_oe       serial output and its tri-state enable
//   cpol, cpha          mode, captured at frame start
//   xfer_len            frame length minus one, captured at frame start
//   we, tx_data         load the transmit holding register
//   rx_data, rx_valid   last received word and pending flag; rd clears flag
//   busy, tx_empty      frame in progress / holding register consumed
//   overrun             sticky: frame completed while a word was pending
//   o_dbg_state         current frame state (spi_pkg encodings)
// Handshake: rx_valid rises one clk after the final sample and stays high
// until a cycle with rd high and no simultaneous frame completion.
module spi_target
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ss,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic        cpol,
    input  logic        cpha,
    input  logic [3:0]  xfer_len,
    input  logic        we,
    input  logic [15:0] tx_data,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rd,
    output logic        busy,
    output logic        tx_empty,
    output logic        overrun,
    output logic [1:0]  o_dbg_state
);

    logic w_ss, w_sck, w_mosi;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst(rst), .i_d(ss),   .o_q(w_ss));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst(rst), .i_d(sck),  .o_q(w_sck));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .i_d(mosi), .o_q(w_mosi));

    logic [1:0]             r_state;
    spi_cfg_t               r_cfg;
    logic                   r_ss_d, r_sck_d;
    logic [SYNC_STAGES-1:0] r_flush;
    logic                   r_armed;
    logic [SPI_MAX_W-1:0]   r_hold, r_shift, r_rx, r_rx_data;
    logic [3:0]             r_bit;
    logic [4:0]             r_cnt;
    logic                   r_miso, r_rx_valid, r_tx_empty;

    logic                 w_ss_fall, w_ss_rise, w_sck_rise, w_sck_fall;
    logic                 w_lead, w_trail, w_sample_edge, w_shift_edge;
    logic [4:0]           w_cnt_next;
    logic                 w_last, w_done;
    logic [SPI_MAX_W-1:0] w_rx_next;

    // A frame may only start after the synchronizers have flushed their reset
    // value and ss has been seen high; an ss held low through reset does not
    // count as a fresh falling edge.
    assign w_ss_fall  = r_armed & r_ss_d & ~w_ss;
    assign w_ss_rise  = ~r_ss_d & w_ss;
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;

    // Leading edge leaves the idle (cpol) level, trailing edge returns to it.
    assign w_lead        = r_cfg.cpol ? w_sck_fall : w_sck_rise;
    assign w_trail       = r_cfg.cpol ? w_sck_rise : w_sck_fall;
    assign w_sample_edge = r_cfg.cpha ? w_trail : w_lead;
    assign w_shift_edge  = r_cfg.cpha ? w_lead  : w_trail;

    assign w_cnt_next = r_cnt + 5'd1;
    assign w_last     = (w_cnt_next == ({1'b0, r_cfg.len} + 5'd1));
    assign w_rx_next  = {r_rx[SPI_MAX_W-2:0], w_mosi};
    assign w_done     = (r_state == S_SHIFT) & ~w_ss_rise & w_sample_edge & w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cfg      <= '0;
            r_ss_d     <= 1'b1;
            r_sck_d    <= 1'b0;
            r_flush    <= '0;
            r_armed    <= 1'b0;
            r_hold     <= '0;
            r_shift    <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_bit      <= '0;
            r_cnt      <= '0;
            r_miso     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_empty <= 1'b1;
        end else begin
            r_ss_d  <= w_ss;
            r_sck_d <= w_sck;
            r_flush <= {r_flush[SYNC_STAGES-2:0], 1'b1};
            r_armed <= r_armed | (r_flush[SYNC_STAGES-1] & w_ss);

            if (we) r_hold <= tx_data;

            // A write in the same cycle as a frame start refills the holding
            // register, so it is not empty.
            if (we)                                r_tx_empty <= 1'b0;
            else if (r_state == S_IDLE && w_ss_fall) r_tx_empty <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_ss_fall) begin
                        r_state <= S_SHIFT;
                        r_cfg   <= '{cpol: cpol, cpha: cpha, len: xfer_len};
                        r_shift <= r_hold;
                        r_miso  <= r_hold[xfer_len];
                        // cpha=0 has already presented the MSB; cpha=1
                        // re-presents it on the first leading edge.
                        r_bit   <= cpha ? xfer_len : xfer_len - 4'd1;
                        r_cnt   <= '0;
                        r_rx    <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_ss_rise) begin
                        r_state <= S_IDLE;
                        r_miso  <= 1'b0;
                    end else begin
                        if (w_sample_edge) begin
                            r_rx  <= w_rx_next;
                            r_cnt <= w_cnt_next;
                            if (w_last) r_state <= S_WAIT;
                        end
                        if (w_shift_edge) begin
                            r_miso <= r_shift[r_bit];
                            r_bit  <= r_bit - 4'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_ss_rise) begin
                        r_state <= S_IDLE;
                        r_miso  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Completion wins over rd so a word arriving with rd is not lost.
            if (w_done) begin
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
            end else if (rd) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_TARGET_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               r_overrun <= 1'b0;
        else if (w_done && r_rx_valid && !rd)  r_overrun <= 1'b1;
    end

    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

    assign miso_oe     = ~w_ss;
    assign miso        = ~w_ss & r_miso;
    assign busy        = (r_state != S_IDLE);
    assign tx_empty    = r_tx_empty;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target -- directed and randomized frames against a word-level
// reference model of the SPI target.
module tb_spi_target;

    localparam int HP = 8;   // sck half period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss = 1'b1, sck = 1'b0, mosi = 1'b0;
    logic        miso, miso_oe;
    logic        cpol = 1'b0, cpha = 1'b0;
    logic [3:0]  xfer_len = 4'd7;
    logic        we = 1'b0;
    logic [15:0] tx_data = '0;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rd = 1'b0;
    logic        busy, tx_empty, overrun;
    logic [1:0]  dbg_state;

    spi_target #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha),
        .xfer_len(xfer_len), .we(we), .tx_data(tx_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rd(rd),
        .busy(busy), .tx_empty(tx_empty), .overrun(overrun),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    logic [15:0] exp_q[$];      // expected miso word per frame
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    logic [15:0] m_hold      = '0;
    logic        m_tx_empty  = 1'b1;
    logic [15:0] m_rx_data   = '0;
    logic        m_rx_valid  = 1'b0;
    logic        m_overrun   = 1'b0;

    function automatic logic [15:0] mask_of(input logic [3:0] len);
        logic [16:0] m;
        m = (17'd1 << (int'(len) + 1)) - 17'd1;
        return m[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_tx(input logic [15:0] w);
        we = 1'b1; tx_data = w;
        tick(1);
        we = 1'b0;
        m_hold = w; m_tx_empty = 1'b0;
    endtask

    task automatic do_rd();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        m_rx_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".rx_data"},  rx_data,   m_rx_data);
        check({tag, ".rx_valid"}, rx_valid,  m_rx_valid);
        check({tag, ".tx_empty"}, tx_empty,  m_tx_empty);
        check({tag, ".overrun"},  overrun,   m_overrun);
        check({tag, ".busy"},     busy,      1'b0);
        check({tag, ".state"},    dbg_state, 2'd0);
        check({tag, ".miso_oe"},  miso_oe,   1'b0);
    endtask

    // Master side of one frame; nbits < len+1 releases ss early (abort).
    task automatic spi_xfer(input string tag, input logic pol, input logic pha,
                            input logic [3:0] len, input logic [15:0] mw, input int nbits);
        logic [15:0] got;
        logic [15:0] exp_w;
        int b;
        got = '0;
        cpol = pol; cpha = pha; xfer_len = len; sck = pol; mosi = 1'b0;
        tick(HP);
        exp_q.push_back(m_hold & mask_of(len));
        m_tx_empty = 1'b1;
        ss = 1'b0;
        if (!pha) mosi = mw[len];
        tick(HP);
        for (int i = 0; i < nbits; i++) begin
            b = int'(len) - i;
            if (!pha) begin
                sck = ~pol;
                got = {got[14:0], miso};
                tick(HP);
                if (i == 0) begin
                    check({tag, ".busy_mid"}, busy, 1'b1);
                    check({tag, ".oe_mid"},   miso_oe, 1'b1);
                end
                sck = pol;
                if (b > 0) mosi = mw[b-1];
                tick(HP);
            end else begin
                sck = ~pol;
                mosi = mw[b];
                tick(HP);
                if (i == 0) begin
                    check({tag, ".busy_mid"}, busy, 1'b1);
                    check({tag, ".oe_mid"},   miso_oe, 1'b1);
                end
                sck = pol;
                got = {got[14:0], miso};
                tick(HP);
            end
        end
        ss = 1'b1;
        tick(HP);
        exp_w = exp_q.pop_front();
        if (nbits == int'(len) + 1) begin
            check({tag, ".miso_word"}, got, exp_w);
`ifdef SPI_TARGET_OVERRUN_EN
            if (m_rx_valid) m_overrun = 1'b1;
`endif
            m_rx_data  = mw & mask_of(len);
            m_rx_valid = 1'b1;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] w, mw;
        logic [3:0]  len;
        logic        pol, pha;

        // reset state
        tick(3);
        check("rst.miso", miso, 1'b0);
        check_idle("rst");
        rst = 1'b0;
        tick(6);

        // mode 0, 8 bits
        load_tx(16'h00A5);
        spi_xfer("m0_8", 1'b0, 1'b0, 4'd7, 16'h003C, 8);
        check_idle("m0_8");
        do_rd();
        check("rd_clear.rx_valid", rx_valid, 1'b0);

        // mode 3, 16 bits
        load_tx(16'h1234);
        spi_xfer("m3_16", 1'b1, 1'b1, 4'd15, 16'hBEEF, 16);
        check_idle("m3_16");
        do_rd();

        // abort after 3 of 8 bits
        load_tx(16'h0077);
        spi_xfer("abort", 1'b0, 1'b0, 4'd7, 16'h00FF, 3);
        check_idle("abort");

        // two frames without rd; second has no we and retransmits
        load_tx(16'h0096);
        spi_xfer("ovr1", 1'b0, 1'b0, 4'd7, 16'h0011, 8);
        check_idle("ovr1");
        spi_xfer("ovr2", 1'b0, 1'b0, 4'd7, 16'h0022, 8);
        check_idle("ovr2");
        check("ovr2.rx_data_lit", rx_data, 16'h0022);

        // reset in the middle of a frame
        cpol = 1'b0; cpha = 1'b0; xfer_len = 4'd7; sck = 1'b0;
        load_tx(16'h00C3);
        ss = 1'b0;
        tick(HP);
        for (int i = 0; i < 3; i++) begin
            sck = ~sck;
            tick(HP);
        end
        rst = 1'b1;
        #1;
        m_hold = '0; m_tx_empty = 1'b1; m_rx_data = '0; m_rx_valid = 1'b0; m_overrun = 1'b0;
        check("rst_mid.miso", miso, 1'b0);
        check_idle("rst_mid");
        sck = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(10);
        check("rst_mid.no_restart", busy, 1'b0);
        ss = 1'b1;
        tick(HP);
        load_tx(16'h005A);
        spi_xfer("post_rst", 1'b0, 1'b0, 4'd7, 16'h00A7, 8);
        check_idle("post_rst");

        // randomized frames
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 1) == 1) do_rd();
            if ($urandom_range(0, 3) != 0) begin
                w = 16'($urandom);
                load_tx(w);
            end
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            len = 4'($urandom_range(0, 15));
            mw  = 16'($urandom);
            spi_xfer("rand", pol, pha, len, mw, int'(len) + 1);
            check_idle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
